// File: rtl/anc_stream_ctrl.sv
// anc_stream_ctrl: frame sequencer in front of the ANC pipeline
// (CORDIC -> noise cancel -> CORDIC1).
//
// Takes complex samples over a valid/ready handshake and issues them into
// the pipeline as one-cycle enable pulses. The pipeline cannot stall, so
// each issue spends one credit from a pool that mirrors the downstream
// output buffer. The block counts issued and returned samples per frame
// and pulses done when the frame has fully drained.
//
// Optional feature, macro ANC_WATCHDOG_EN: a drain watchdog. If no result
// comes back for TIMEOUT cycles while samples are still in flight, the
// block sets err and parks in ERR until reset. With the macro undefined,
// there is no watchdog counter and no ERR state.

module anc_stream_ctrl #(
    parameter int DATA_W  = 32,
    parameter int FRAME_W = 16,
    parameter int CREDITS = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [FRAME_W-1:0]                 frame_len,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic signed [DATA_W-1:0]           s_re,
    input  logic signed [DATA_W-1:0]           s_im,
    output logic                               pipe_enable_in,
    output logic signed [DATA_W-1:0]           pipe_x_re,
    output logic signed [DATA_W-1:0]           pipe_x_im,
    input  logic                               pipe_enable_out,
    input  logic                               credit_return,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(CREDITS+1)-1:0]       inflight,
    output logic                               err
);

    localparam int CNT_W = $clog2(CREDITS+1);

`ifdef ANC_WATCHDOG_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;
    localparam int WD_W = $clog2(TIMEOUT+1);
    logic [WD_W-1:0] wd_cnt;
`else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   credits, credits_nxt;
    logic [CNT_W-1:0]   inflight_nxt;
    logic [FRAME_W-1:0] issued, issued_nxt;
    logic [FRAME_W-1:0] returned, returned_nxt;
    logic [FRAME_W-1:0] frame_len_q;
    logic               latch_len;
    logic               err_nxt;
    logic               issue;
    logic               ret_ok;
    logic               cr_ok;

    // Outputs decoded from registered state only; no input-to-output paths.
    assign s_ready = (state == RUN) && (credits != '0) && (issued < frame_len_q);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign issue   = s_valid && s_ready;

    // Next-state and net counter updates. Underflow and overflow events set
    // err and are dropped, so the counters saturate instead of wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the case; a path that
        // leaves one unassigned would infer a latch.
        state_nxt    = state;
        latch_len    = 1'b0;
        ret_ok       = pipe_enable_out && (inflight != '0);
        cr_ok        = credit_return && (credits != CNT_W'(CREDITS));
        err_nxt      = err
                     | (pipe_enable_out && (inflight == '0))
                     | (credit_return && (credits == CNT_W'(CREDITS)));
        inflight_nxt = inflight + CNT_W'(issue) - CNT_W'(ret_ok);
        credits_nxt  = credits - CNT_W'(issue) + CNT_W'(cr_ok);
        issued_nxt   = issued + FRAME_W'(issue);
        returned_nxt = (ret_ok && (returned != '1)) ? returned + FRAME_W'(1) : returned;

        case (state)
            IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        state_nxt    = RUN;
                        latch_len    = 1'b1;
                        issued_nxt   = '0;
                        returned_nxt = '0;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (issued_nxt == frame_len_q)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Uses the post-update counts so done follows the last
                // result by a single cycle.
                if ((inflight_nxt == '0) && (returned_nxt == frame_len_q))
                    state_nxt = DONE;
`ifdef ANC_WATCHDOG_EN
                else if ((wd_cnt == WD_W'(TIMEOUT)) && (inflight != '0)) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
                end
`endif
            end
            DONE: state_nxt = IDLE;
`ifdef ANC_WATCHDOG_EN
            ERR:  state_nxt = ERR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and the registered pipeline issue stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state          <= IDLE;
            credits        <= CNT_W'(CREDITS);
            inflight       <= '0;
            issued         <= '0;
            returned       <= '0;
            frame_len_q    <= '0;
            err            <= 1'b0;
            pipe_enable_in <= 1'b0;
            pipe_x_re      <= '0;
            pipe_x_im      <= '0;
        end else begin
            state          <= state_nxt;
            credits        <= credits_nxt;
            inflight       <= inflight_nxt;
            issued         <= issued_nxt;
            returned       <= returned_nxt;
            err            <= err_nxt;
            pipe_enable_in <= issue;
            if (latch_len)
                frame_len_q <= frame_len;
            if (issue) begin
                pipe_x_re <= s_re;
                pipe_x_im <= s_im;
            end
        end
    end

`ifdef ANC_WATCHDOG_EN
    // Drain watchdog: counts idle DRAIN cycles, restarts on every result.
    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= '0;
        else if ((state != DRAIN) || pipe_enable_out)
            wd_cnt <= '0;
        else if (wd_cnt != WD_W'(TIMEOUT))
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`endif

endmodule

// File: tb/tb_anc_stream_ctrl.sv
// Directed testbench for anc_stream_ctrl. Inputs change 1 time unit after
// the rising edge and outputs are sampled at that same point, so every
// registered value seen belongs to the edge just taken.

module tb_anc_stream_ctrl;

    localparam int DATA_W  = 32;
    localparam int FRAME_W = 16;
    localparam int CREDITS = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(CREDITS+1);

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [FRAME_W-1:0]       frame_len;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_re;
    logic signed [DATA_W-1:0] s_im;
    logic                     pipe_enable_in;
    logic signed [DATA_W-1:0] pipe_x_re;
    logic signed [DATA_W-1:0] pipe_x_im;
    logic                     pipe_enable_out;
    logic                     credit_return;
    logic                     busy;
    logic                     done;
    logic [CW-1:0]            inflight;
    logic                     err;

    int checks = 0;
    int passed = 0;

    anc_stream_ctrl #(
        .DATA_W (DATA_W),
        .FRAME_W(FRAME_W),
        .CREDITS(CREDITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .frame_len      (frame_len),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_re           (s_re),
        .s_im           (s_im),
        .pipe_enable_in (pipe_enable_in),
        .pipe_x_re      (pipe_x_re),
        .pipe_x_im      (pipe_x_im),
        .pipe_enable_out(pipe_enable_out),
        .credit_return  (credit_return),
        .busy           (busy),
        .done           (done),
        .inflight       (inflight),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start           = 1'b0;
        frame_len       = '0;
        s_valid         = 1'b0;
        s_re            = '0;
        s_im            = '0;
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({s_ready, pipe_enable_in, busy, done, err} !== 5'b00000)
            $display("FAIL reset_flags: got %b want 00000", {s_ready, pipe_enable_in, busy, done, err});
        else passed++;
        checks++;
        if (inflight !== CW'(0)) $display("FAIL reset_inflight: got %0d want 0", inflight);
        else passed++;
        checks++;
        if ({pipe_x_re, pipe_x_im} !== 64'd0)
            $display("FAIL reset_pipe_x: got %h %h want 0 0", pipe_x_re, pipe_x_im);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal;
        logic signed [DATA_W-1:0] dre [4];
        logic signed [DATA_W-1:0] dim [4];
        int inf_tab [9];
        logic [3:0] exp_flags;
        dre = '{32'sh0000_1234, -32'sd5, 32'sh7FFF_FFFF, 32'sh8000_0000};
        dim = '{32'sd1, -32'sd1, 32'sh0ABC_DEF0, -32'sd1000};
        inf_tab = '{0, 0, 1, 2, 2, 2, 1, 0, 0};
        start = 1'b1;
        frame_len = 16'd4;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_flags = {(c <= 4), (c >= 2 && c <= 5), (c == 7), (c <= 7)};
            checks++;
            if ({s_ready, pipe_enable_in, done, busy} !== exp_flags)
                $display("FAIL nominal_flags c%0d: got %b want %b (rdy,pe_in,done,busy)",
                         c, {s_ready, pipe_enable_in, done, busy}, exp_flags);
            else passed++;
            checks++;
            if (inflight !== CW'(inf_tab[c]))
                $display("FAIL nominal_inflight c%0d: got %0d want %0d", c, inflight, inf_tab[c]);
            else passed++;
            if (c >= 2 && c <= 5) begin
                checks++;
                if ({pipe_x_re, pipe_x_im} !== {dre[c-2], dim[c-2]})
                    $display("FAIL nominal_data c%0d: got %h %h want %h %h",
                             c, pipe_x_re, pipe_x_im, dre[c-2], dim[c-2]);
                else passed++;
            end
            if (c == 6 || c == 7) begin
                checks++;
                if ({pipe_x_re, pipe_x_im} !== {dre[3], dim[3]})
                    $display("FAIL nominal_hold c%0d: got %h %h want %h %h",
                             c, pipe_x_re, pipe_x_im, dre[3], dim[3]);
                else passed++;
            end
            s_valid = (c <= 4);
            if (c <= 4) begin
                s_re = dre[c-1];
                s_im = dim[c-1];
            end
            pipe_enable_out = (c >= 3 && c <= 6);
            credit_return   = (c >= 3 && c <= 6);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_credit_stall;
        start = 1'b1;
        frame_len = 16'd12;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (s_ready !== (c <= 8))
                $display("FAIL stall_ready c%0d: got %b want %b", c, s_ready, (c <= 8));
            else passed++;
            s_re = 32'(c);
            tick();
        end
        // c10: still out of credits; one credit comes back this cycle
        checks++;
        if (s_ready !== 1'b0 || inflight !== CW'(8))
            $display("FAIL stall_hold: got rdy=%b inflight=%0d want rdy=0 inflight=8", s_ready, inflight);
        else passed++;
        credit_return = 1'b1;
        s_re = 32'sd10;
        tick();
        // c11: the returned credit allows the 9th issue now
        credit_return = 1'b0;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL stall_resume: got rdy=%b want 1", s_ready);
        else passed++;
        s_re = 32'sd11;
        tick();
        // c12: 9th sample appears, pool empty again
        checks++;
        if ({pipe_enable_in, s_ready} !== 2'b10 || pipe_x_re !== 32'sd11 || inflight !== CW'(9))
            $display("FAIL stall_ninth: got pe=%b rdy=%b x=%0d inflight=%0d want pe=1 rdy=0 x=11 inflight=9",
                     pipe_enable_in, s_ready, pipe_x_re, inflight);
        else passed++;
        for (int k = 0; k < 11; k++) begin
            pipe_enable_out = 1'b1;
            credit_return   = 1'b1;
            tick();
        end
        credit_return = 1'b0;
        s_valid = 1'b0;
        tick();
        pipe_enable_out = 1'b0;
        checks++;
        if ({done, err} !== 2'b10 || inflight !== CW'(0))
            $display("FAIL stall_done: got done=%b err=%b inflight=%0d want done=1 err=0 inflight=0",
                     done, err, inflight);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_simultaneous;
        start = 1'b1;
        frame_len = 16'd2;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_re = 32'sd100;
        s_im = -32'sd100;
        tick();
        checks++;
        if (inflight !== CW'(1)) $display("FAIL simul_pre: got inflight=%0d want 1", inflight);
        else passed++;
        s_re = 32'sd200;
        s_im = -32'sd200;
        pipe_enable_out = 1'b1;
        credit_return   = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (inflight !== CW'(1) || pipe_enable_in !== 1'b1 || pipe_x_re !== 32'sd200 || err !== 1'b0)
            $display("FAIL simul_net: got inflight=%0d pe=%b x=%0d err=%b want 1 1 200 0",
                     inflight, pipe_enable_in, pipe_x_re, err);
        else passed++;
        tick();
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
        checks++;
        if (done !== 1'b1 || inflight !== CW'(0))
            $display("FAIL simul_done: got done=%b inflight=%0d want 1 0", done, inflight);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_edge_starts;
        // zero-length frame
        start = 1'b1;
        frame_len = 16'd0;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy, pipe_enable_in} !== 3'b110)
            $display("FAIL zero_len_done: got %b want 110 (done,busy,pe_in)", {done, busy, pipe_enable_in});
        else passed++;
        tick();
        checks++;
        if ({done, busy, pipe_enable_in} !== 3'b000)
            $display("FAIL zero_len_after: got %b want 000", {done, busy, pipe_enable_in});
        else passed++;
        // start during RUN must not relatch frame_len
        start = 1'b1;
        frame_len = 16'd2;
        tick();
        frame_len = 16'd5;
        s_valid = 1'b1;
        tick();
        start = 1'b0;
        tick();
        s_valid = 1'b0;
        checks++;
        if ({s_ready, busy} !== 2'b01)
            $display("FAIL run_start_ignored: got rdy=%b busy=%b want rdy=0 busy=1", s_ready, busy);
        else passed++;
        pipe_enable_out = 1'b1;
        credit_return   = 1'b1;
        tick();
        tick();
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
        checks++;
        if (done !== 1'b1) $display("FAIL run_start_done: got done=%b want 1", done);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        frame_len = 16'd1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_re = 32'sd7;
        tick();
        s_valid = 1'b0;
        pipe_enable_out = 1'b1;
        credit_return   = 1'b1;
        tick();
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
        checks++;
        if (done !== 1'b1) $display("FAIL b2b_first_done: got done=%b want 1", done);
        else passed++;
        // start in the DONE cycle itself is ignored
        start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_done_start: got busy=%b want 0", busy);
        else passed++;
        // start in the cycle after done is accepted
        tick();
        start = 1'b0;
        checks++;
        if ({busy, s_ready} !== 2'b11)
            $display("FAIL b2b_accept: got busy=%b rdy=%b want 1 1", busy, s_ready);
        else passed++;
        s_valid = 1'b1;
        s_re = 32'sd9;
        tick();
        s_valid = 1'b0;
        pipe_enable_out = 1'b1;
        credit_return   = 1'b1;
        tick();
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
        checks++;
        if (done !== 1'b1) $display("FAIL b2b_second_done: got done=%b want 1", done);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_errors;
        // result with nothing in flight
        pipe_enable_out = 1'b1;
        tick();
        pipe_enable_out = 1'b0;
        checks++;
        if (err !== 1'b1 || inflight !== CW'(0))
            $display("FAIL err_underflow: got err=%b inflight=%0d want 1 0", err, inflight);
        else passed++;
        tick();
        checks++;
        if (err !== 1'b1) $display("FAIL err_sticky: got err=%b want 1", err);
        else passed++;
        pulse_reset();
        checks++;
        if (err !== 1'b0) $display("FAIL err_cleared: got err=%b want 0", err);
        else passed++;
        // credit return into a full pool
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        checks++;
        if (err !== 1'b1) $display("FAIL err_overflow: got err=%b want 1", err);
        else passed++;
        pulse_reset();
        // reset in the middle of a frame with three samples in flight
        start = 1'b1;
        frame_len = 16'd5;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_re = -32'sd3;
        s_im = 32'sd3;
        tick();
        tick();
        tick();
        s_valid = 1'b0;
        checks++;
        if (inflight !== CW'(3) || pipe_enable_in !== 1'b1)
            $display("FAIL midrun_pre: got inflight=%0d pe=%b want 3 1", inflight, pipe_enable_in);
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if ({s_ready, pipe_enable_in, busy, done, err} !== 5'b00000 || inflight !== CW'(0)
            || {pipe_x_re, pipe_x_im} !== 64'd0)
            $display("FAIL midrun_reset: got flags=%b inflight=%0d x=%h %h want 00000 0 0 0",
                     {s_ready, pipe_enable_in, busy, done, err}, inflight, pipe_x_re, pipe_x_im);
        else passed++;
        reset = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_watchdog;
        start = 1'b1;
        frame_len = 16'd2;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        pipe_enable_out = 1'b1;
        credit_return   = 1'b1;
        tick();
        pipe_enable_out = 1'b0;
        credit_return   = 1'b0;
        for (int k = 0; k < TIMEOUT + 4; k++) tick();
`ifdef ANC_WATCHDOG_EN
        checks++;
        if ({err, busy, s_ready} !== 3'b110)
            $display("FAIL watchdog_trip: got err=%b busy=%b rdy=%b want 1 1 0", err, busy, s_ready);
        else passed++;
`else
        checks++;
        if ({err, busy} !== 2'b01 || inflight !== CW'(1))
            $display("FAIL watchdog_absent: got err=%b busy=%b inflight=%0d want 0 1 1", err, busy, inflight);
        else passed++;
`endif
        pulse_reset();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_nominal();
        test_credit_stall();
        test_simultaneous();
        test_edge_starts();
        test_back_to_back();
        test_errors();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
